seq_checker: RTL and testbench

SEQ_CHECKER -- requirements
Module: seq_checker

---
 rtl/seq_checker_pkg.sv | 22 ++
 rtl/seq_checker_sat_counter.sv | 40 ++++
 rtl/seq_checker.sv | 137 +++++++++++++
 tb/tb_seq_checker.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_checker_pkg.sv
// Shared defaults, legal ranges and the parameter legality check for the
// seq_checker block and its saturating counters.
package seq_checker_pkg;

    localparam int DLY_MIN_DEFAULT = 1;
    localparam int DLY_MAX_DEFAULT = 3;
    localparam int J_LEN_DEFAULT   = 4;
    localparam int CNT_W_DEFAULT   = 16;

    localparam int DLY_MAX_LIMIT   = 15;
    localparam int J_LEN_LIMIT     = 32;
    localparam int CNT_W_MIN       = 4;
    localparam int CNT_W_MAX       = 32;

    function automatic bit params_ok(input int dly_min, input int dly_max,
                                     input int j_len, input int cnt_w);
        return (dly_min >= 0) && (dly_min <= dly_max) && (dly_max <= DLY_MAX_LIMIT) &&
               (j_len >= 1) && (j_len <= J_LEN_LIMIT) &&
               (cnt_w >= CNT_W_MIN) && (cnt_w <= CNT_W_MAX);
    endfunction

endpackage

// File: rtl/seq_checker_sat_counter.sv
// Event counter that adds a variable amount per cycle and sticks at all-ones;
// a synchronous clear takes priority over the same-cycle increment.
module sat_counter #(
    parameter int W     = 16,
    parameter int INC_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [INC_W-1:0] inc,
    output logic [W-1:0]     count
);

    localparam int SUM_W = ((W > INC_W) ? W : INC_W) + 1;

    logic [W-1:0]     count_q, count_d;
    logic [SUM_W-1:0] sum;

    always_comb begin
        sum = SUM_W'(count_q) + SUM_W'(inc);
        if (clr) begin
            count_d = '0;
        end else if (sum > SUM_W'({W{1'b1}})) begin
            count_d = '1;
        end else begin
            count_d = sum[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_checker.sv
// Monitors "C, then B after DLY_MIN..DLY_MAX cycles, then A" followed by J_LEN
// cycles of J and one cycle of K, tracking every overlapping attempt.
module seq_checker
    import seq_checker_pkg::*;
#(
    parameter int DLY_MIN = DLY_MIN_DEFAULT,
    parameter int DLY_MAX = DLY_MAX_DEFAULT,
    parameter int J_LEN   = J_LEN_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    input  logic             J,
    input  logic             K,
    input  logic             X,
    input  logic             CNT_CLR,
    output logic             PASS,
    output logic             FAIL,
    output logic             ACTIVE,
    output logic [CNT_W-1:0] PASS_CNT,
    output logic [CNT_W-1:0] FAIL_CNT
);

    localparam int FCNT_W = $clog2(J_LEN + 2);

    if (!params_ok(DLY_MIN, DLY_MAX, J_LEN, CNT_W)) begin : g_bad_params
        $error("seq_checker: illegal parameter combination");
    end

    logic [DLY_MAX:0]  c_hist_q, c_hist_d;
    logic              b_q, b_d;
    logic [J_LEN:0]    obl_q, obl_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic              active_q, active_d;

    logic              c_window;
    logic              match;
    logic              pass_now;
    logic [FCNT_W-1:0] fail_num;
    logic              pass_inc;
    logic [FCNT_W-1:0] fail_inc;

    // obl_q[i] set means some attempt is checked at stage i on this edge
    always_comb begin
        c_window = 1'b0;
        for (int d = DLY_MIN; d <= DLY_MAX; d++) begin
            c_window = c_window | c_hist_q[d];
        end
        match    = A & b_q & c_window;
        pass_now = obl_q[J_LEN] & K;

        fail_num = '0;
        for (int i = 0; i < J_LEN; i++) begin
            if (obl_q[i] && !J) begin
                fail_num = fail_num + FCNT_W'(1);
            end
        end
        if (obl_q[J_LEN] && !K) begin
            fail_num = fail_num + FCNT_W'(1);
        end

        c_hist_d[0] = C;
        for (int n = 1; n <= DLY_MAX; n++) begin
            c_hist_d[n] = c_hist_q[n-1];
        end
        b_d      = B;
        obl_d[0] = match;
        for (int i = 0; i < J_LEN; i++) begin
            obl_d[i+1] = obl_q[i] & J;
        end
        pass_d   = pass_now;
        fail_d   = (fail_num != '0);
        pass_inc = pass_now;
        fail_inc = fail_num;

        // Disable wipes history and attempts, and this edge decides nothing
        if (X) begin
            c_hist_d = '0;
            b_d      = 1'b0;
            obl_d    = '0;
            pass_d   = 1'b0;
            fail_d   = 1'b0;
            pass_inc = 1'b0;
            fail_inc = '0;
        end
        active_d = |obl_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            c_hist_q <= '0;
            b_q      <= 1'b0;
            obl_q    <= '0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            c_hist_q <= c_hist_d;
            b_q      <= b_d;
            obl_q    <= obl_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            active_q <= active_d;
        end
    end

    sat_counter #(
        .W     (CNT_W),
        .INC_W (1)
    ) u_pass_cnt (
        .clk   (CLK),
        .rst   (RST),
        .clr   (CNT_CLR),
        .inc   (pass_inc),
        .count (PASS_CNT)
    );

    sat_counter #(
        .W     (CNT_W),
        .INC_W (FCNT_W)
    ) u_fail_cnt (
        .clk   (CLK),
        .rst   (RST),
        .clr   (CNT_CLR),
        .inc   (fail_inc),
        .count (FAIL_CNT)
    );

    assign PASS   = pass_q;
    assign FAIL   = fail_q;
    assign ACTIVE = active_q;

endmodule

// File: tb/tb_seq_checker.sv
// Directed vector table followed by randomized traffic, both checked against
// hand-derived values or a cycle-history reference model of the sequence rules.
module tb_seq_checker;

    localparam int DMIN     = 1;
    localparam int DMAX     = 3;
    localparam int JL       = 4;
    localparam int TB_CNT_W = 4;
    localparam int CNT_SAT  = (1 << TB_CNT_W) - 1;
    localparam int HIST_N   = 8192;
    localparam int N_RAND   = 3000;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                a = 1'b0, b = 1'b0, c = 1'b0, j = 1'b0, k = 1'b0;
    logic                x = 1'b0, cnt_clr = 1'b0;
    logic                pass_o, fail_o, active_o;
    logic [TB_CNT_W-1:0] pass_cnt, fail_cnt;

    always #5 clk = ~clk;

    seq_checker #(
        .DLY_MIN (DMIN),
        .DLY_MAX (DMAX),
        .J_LEN   (JL),
        .CNT_W   (TB_CNT_W)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .A        (a),
        .B        (b),
        .C        (c),
        .J        (j),
        .K        (k),
        .X        (x),
        .CNT_CLR  (cnt_clr),
        .PASS     (pass_o),
        .FAIL     (fail_o),
        .ACTIVE   (active_o),
        .PASS_CNT (pass_cnt),
        .FAIL_CNT (fail_cnt)
    );

    typedef struct packed {
        logic rst, x, clr, a, b, c, j, k;
    } stim_t;

    typedef struct {
        string name;
        stim_t s;
        logic  e_pass, e_fail, e_active;
        int    e_pcnt, e_fcnt;
    } vec_t;

    vec_t vecs[$];
    int   vectors_applied = 0;
    int   miscompares     = 0;

    // Reference model: raw input history plus the start cycle of every live attempt
    bit   hist_b[HIST_N];
    bit   hist_c[HIST_N];
    int   now_t      = 0;
    int   valid_from = 0;
    int   starts[$];
    bit   m_pass, m_fail, m_active;
    int   m_pcnt = 0, m_fcnt = 0;

    function automatic bit past_b(input int i);
        return (i >= valid_from) ? hist_b[i] : 1'b0;
    endfunction

    function automatic bit past_c(input int i);
        return (i >= valid_from) ? hist_c[i] : 1'b0;
    endfunction

    task automatic model_edge(input stim_t s);
        int  keep[$];
        int  npass;
        int  nfail;
        bit  hit;
        hist_b[now_t] = s.b;
        hist_c[now_t] = s.c;
        if (s.rst || s.x) begin
            starts.delete();
            valid_from = now_t + 1;
            m_pass   = 1'b0;
            m_fail   = 1'b0;
            m_active = 1'b0;
            if (s.rst || s.clr) begin
                m_pcnt = 0;
                m_fcnt = 0;
            end
        end else begin
            npass = 0;
            nfail = 0;
            foreach (starts[i]) begin
                if (now_t - starts[i] - 1 < JL) begin
                    if (s.j) keep.push_back(starts[i]);
                    else     nfail++;
                end else begin
                    if (s.k) npass++;
                    else     nfail++;
                end
            end
            starts = keep;
            hit = 1'b0;
            for (int d = DMIN; d <= DMAX; d++) begin
                if (past_c(now_t - 1 - d)) hit = 1'b1;
            end
            if (s.a && past_b(now_t - 1) && hit) starts.push_back(now_t);
            m_pass   = (npass > 0);
            m_fail   = (nfail > 0);
            m_active = (starts.size() > 0);
            if (s.clr) begin
                m_pcnt = 0;
                m_fcnt = 0;
            end else begin
                m_pcnt = (m_pcnt + (npass > 0 ? 1 : 0) > CNT_SAT) ? CNT_SAT : m_pcnt + (npass > 0 ? 1 : 0);
                m_fcnt = (m_fcnt + nfail > CNT_SAT) ? CNT_SAT : m_fcnt + nfail;
            end
        end
        now_t++;
    endtask

    function automatic stim_t parse(input string ins);
        stim_t r;
        r = '0;
        for (int i = 0; i < ins.len(); i++) begin
            case (ins[i])
                "R": r.rst = 1'b1;
                "X": r.x   = 1'b1;
                "Z": r.clr = 1'b1;
                "A": r.a   = 1'b1;
                "B": r.b   = 1'b1;
                "C": r.c   = 1'b1;
                "J": r.j   = 1'b1;
                "K": r.k   = 1'b1;
                default: ;
            endcase
        end
        return r;
    endfunction

    function automatic void add(input string n, input string ins, input bit p, input bit f,
                                input bit act, input int pc, input int fc);
        vec_t v;
        v.name     = n;
        v.s        = parse(ins);
        v.e_pass   = p;
        v.e_fail   = f;
        v.e_active = act;
        v.e_pcnt   = pc;
        v.e_fcnt   = fc;
        vecs.push_back(v);
    endfunction

    task automatic apply_stimulus(input stim_t s);
        @(negedge clk);
        rst     = s.rst;
        x       = s.x;
        cnt_clr = s.clr;
        a       = s.a;
        b       = s.b;
        c       = s.c;
        j       = s.j;
        k       = s.k;
        @(posedge clk);
        model_edge(s);
        #1;
    endtask

    task automatic check_output(input string name, input bit ep, input bit ef, input bit ea,
                                input int pc, input int fc);
        vectors_applied++;
        if (pass_o !== ep || fail_o !== ef || active_o !== ea ||
            pass_cnt !== TB_CNT_W'(pc) || fail_cnt !== TB_CNT_W'(fc)) begin
            miscompares++;
            $display("[TB] FAIL %s: PASS/FAIL/ACTIVE/PCNT/FCNT got %0b/%0b/%0b/%0d/%0d want %0b/%0b/%0b/%0d/%0d",
                     name, pass_o, fail_o, active_o, pass_cnt, fail_cnt, ep, ef, ea, pc, fc);
        end
    endtask

    initial begin
        stim_t s;

        add("idle", "R", 0,0,0,0,0); add("idle", "C", 0,0,0,0,0); add("idle", "B", 0,0,0,0,0);
        add("idle", "B", 0,0,0,0,0); add("idle", "B", 0,0,0,0,0);

        add("pass", "R", 0,0,0,0,0); add("pass", "C", 0,0,0,0,0); add("pass", "B", 0,0,0,0,0);
        add("pass", "A", 0,0,1,0,0);
        for (int i = 0; i < 4; i++) add("pass", "J", 0,0,1,0,0);
        add("pass", "K", 1,0,0,1,0); add("pass", "", 0,0,0,1,0);

        add("late_k", "R", 0,0,0,0,0); add("late_k", "C", 0,0,0,0,0); add("late_k", "B", 0,0,0,0,0);
        add("late_k", "A", 0,0,1,0,0);
        for (int i = 0; i < 4; i++) add("late_k", "J", 0,0,1,0,0);
        add("late_k", "", 0,1,0,0,1); add("late_k", "K", 0,0,0,0,1);

        add("overlap", "R", 0,0,0,0,0); add("overlap", "C", 0,0,0,0,0); add("overlap", "B", 0,0,0,0,0);
        add("overlap", "BA", 0,0,1,0,0); add("overlap", "BA", 0,1,1,0,1); add("overlap", "A", 0,1,1,0,2);
        for (int i = 0; i < 4; i++) add("overlap", "J", 0,0,1,0,2);
        add("overlap", "K", 1,0,0,1,2);

        add("disable", "R", 0,0,0,0,0); add("disable", "C", 0,0,0,0,0); add("disable", "B", 0,0,0,0,0);
        add("disable", "B", 0,0,0,0,0); add("disable", "A", 0,0,1,0,0); add("disable", "J", 0,0,1,0,0);
        add("disable", "J", 0,0,1,0,0); add("disable", "X", 0,0,0,0,0); add("disable", "J", 0,0,0,0,0);
        add("disable", "J", 0,0,0,0,0); add("disable", "K", 0,0,0,0,0);

        add("mid_rst", "R", 0,0,0,0,0); add("mid_rst", "C", 0,0,0,0,0); add("mid_rst", "B", 0,0,0,0,0);
        add("mid_rst", "A", 0,0,1,0,0); add("mid_rst", "J", 0,0,1,0,0); add("mid_rst", "J", 0,0,1,0,0);
        add("mid_rst", "R", 0,0,0,0,0); add("mid_rst", "C", 0,0,0,0,0); add("mid_rst", "B", 0,0,0,0,0);
        add("mid_rst", "A", 0,0,1,0,0);
        for (int i = 0; i < 4; i++) add("mid_rst", "J", 0,0,1,0,0);
        add("mid_rst", "K", 1,0,0,1,0); add("cnt_clr", "Z", 0,0,0,0,0);

        add("clr_prio", "C", 0,0,0,0,0); add("clr_prio", "B", 0,0,0,0,0); add("clr_prio", "A", 0,0,1,0,0);
        for (int i = 0; i < 4; i++) add("clr_prio", "J", 0,0,1,0,0);
        add("clr_prio", "KZ", 1,0,0,0,0); add("clr_prio", "", 0,0,0,0,0);

        add("d0_reject", "R", 0,0,0,0,0); add("d0_reject", "CB", 0,0,0,0,0); add("d0_reject", "A", 0,0,0,0,0);

        add("dmax_ok", "R", 0,0,0,0,0); add("dmax_ok", "C", 0,0,0,0,0); add("dmax_ok", "", 0,0,0,0,0);
        add("dmax_ok", "", 0,0,0,0,0); add("dmax_ok", "B", 0,0,0,0,0); add("dmax_ok", "A", 0,0,1,0,0);
        add("dmax_ok", "", 0,1,0,0,1);

        add("d4_reject", "R", 0,0,0,0,0); add("d4_reject", "C", 0,0,0,0,0);
        for (int i = 0; i < 3; i++) add("d4_reject", "", 0,0,0,0,0);
        add("d4_reject", "B", 0,0,0,0,0); add("d4_reject", "A", 0,0,0,0,0);

        add("merge", "R", 0,0,0,0,0); add("merge", "C", 0,0,0,0,0); add("merge", "C", 0,0,0,0,0);
        add("merge", "B", 0,0,0,0,0); add("merge", "A", 0,0,1,0,0); add("merge", "", 0,1,0,0,1);

        add("x_hist", "R", 0,0,0,0,0); add("x_hist", "C", 0,0,0,0,0); add("x_hist", "BX", 0,0,0,0,0);
        add("x_hist", "A", 0,0,0,0,0);
        add("x_match", "R", 0,0,0,0,0); add("x_match", "C", 0,0,0,0,0); add("x_match", "B", 0,0,0,0,0);
        add("x_match", "AX", 0,0,0,0,0); add("x_match", "", 0,0,0,0,0);

        add("ignore", "R", 0,0,0,0,0); add("ignore", "C", 0,0,0,0,0); add("ignore", "B", 0,0,0,0,0);
        add("ignore", "A", 0,0,1,0,0);
        for (int i = 0; i < 4; i++) add("ignore", "JK", 0,0,1,0,0);
        add("ignore", "JK", 1,0,0,1,0);

        $display("[TB] applying %0d directed vectors", vecs.size());
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].s);
            check_output($sformatf("%s[%0d]", vecs[i].name, i), vecs[i].e_pass, vecs[i].e_fail,
                         vecs[i].e_active, vecs[i].e_pcnt, vecs[i].e_fcnt);
        end

        $display("[TB] applying %0d random vectors", N_RAND);
        s = parse("R");
        apply_stimulus(s);
        check_output("rand_reset", m_pass, m_fail, m_active, m_pcnt, m_fcnt);
        for (int n = 0; n < N_RAND && now_t < HIST_N - 1; n++) begin
            s.rst = ($urandom_range(0, 999) < 3);
            s.x   = ($urandom_range(0, 99) < 2);
            s.clr = ($urandom_range(0, 99) < 2);
            s.a   = ($urandom_range(0, 99) < 45);
            s.b   = ($urandom_range(0, 99) < 55);
            s.c   = ($urandom_range(0, 99) < 40);
            s.j   = ($urandom_range(0, 99) < 85);
            s.k   = ($urandom_range(0, 99) < 60);
            apply_stimulus(s);
            check_output($sformatf("rand[%0d]", n), m_pass, m_fail, m_active, m_pcnt, m_fcnt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
